mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and sequencer for the five-stage pipeline. It shares one memory port between the IF-stage instruction fetch and the LS-stage load/store. Each transaction is sequenced through a request/acknowledge handshake toward memory. The block generates the stall signals that hold PC_reg/ID_reg (fetch side) and the LS/WB advance (data side) while a transaction is pending.

## Interface
- XLEN, 64, data/address width (matches `XLEN)
- INST_W, 32, instruction width (matches `inst_len)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  branch/jump redirect (is_jump); discards in-flight fetch result
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  XLEN  fetch address (pc_new)
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid
- if_rdata_o  out  INST_W  fetched instruction
- ls_req_i  in  1  load/store request; held until ls_gnt_o
- ls_we_i  in  1  1 = store
- ls_addr_i  in  XLEN  data address (alures_ls)
- ls_wdata_i  in  XLEN  store data
- ls_wmask_i  in  8  byte write mask
- ls_gnt_o  out  1  data request accepted this cycle
- ls_rvalid_o  out  1  one-cycle pulse: load data valid / store complete
- ls_rdata_o  out  XLEN  load data
- stall_if_o  out  1  hold fetch side
- stall_ls_o  out  1  hold LS stage
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o, mem_addr_o (XLEN), mem_wdata_o (XLEN), mem_wmask_o (8)  out  registered command
- mem_ack_i  in  1  one-cycle completion
- mem_rdata_i  in  XLEN  read data, valid with mem_ack_i

## Operation
- States: IDLE, IF_BUSY, LS_BUSY.
- Accept point: state IDLE, or a BUSY state in a cycle with mem_ack_i=1. At an accept point, if any request is present, exactly one grant (gnt) asserts combinationally.
- On grant: command captured into mem_* registers; state goes to IF_BUSY or LS_BUSY. The fetch command has mem_we_o=0 and mem_wmask_o=0.
- No request at an accept point: state goes to IDLE.
- Priority, default: LS over IF.
- BUSY: mem_req_o=1 and the command is stable until mem_ack_i.
- On ack in IF_BUSY: if_rdata_o registered as mem_rdata_i[63:32] if mem_addr_o[2]=1, else mem_rdata_i[31:0]. if_rvalid_o pulses the next cycle unless suppressed (see flush).
- On ack in LS_BUSY: a load registers ls_rdata_o = mem_rdata_i. A store leaves ls_rdata_o unchanged. ls_rvalid_o pulses the next cycle in both cases.
- Flush: flush_i during IF_BUSY or on its ack cycle sets a discard flag; the matching if_rvalid_o is suppressed. The memory transaction still completes; it is never aborted. The flag clears when that transaction's rvalid would have fired. flush_i has no effect on LS transactions.
- stall_if_o = (if_req_i & ~if_gnt_o) | state==IF_BUSY.
- stall_ls_o = (ls_req_i & ~ls_gnt_o) | state==LS_BUSY.

## Timing
- Reset (async, immediate), all outputs and state:
  - state=IDLE
  - mem_req_o=0, mem_* command registers=0
  - if_rvalid_o=ls_rvalid_o=0
  - if_rdata_o=ls_rdata_o=0
  - discard flag=0
  - round-robin pointer=IF (see Configuration)
- Reset mid-transaction: mem_req_o drops immediately and any later mem_ack_i is ignored. Memory shares rst_n.
- Latency, with grant in cycle 0 and mem_ack_i in cycle N (N≥1):
  - mem_req_o high from cycle 1 through cycle N.
  - rvalid pulses in cycle N+1.
  - Minimum grant-to-rvalid latency is 2 cycles.
- Back-to-back: a request granted on an ack cycle puts the next mem_req_o in cycle N+1 with no idle cycle.
- mem_ack_i outside BUSY: ignored.
- Simultaneous if_req_i and ls_req_i at an accept point: one grant only; the loser sees its stall held.

## Configuration
- ARB_RR_EN undefined: fixed priority, LS over IF.
- ARB_RR_EN defined: round-robin on simultaneous requests.
  - A 1-bit pointer records the last granted requester; the other requester wins a tie.
  - The pointer resets to IF, so the first tie goes to LS.
  - A lone requester is always granted.

## Test plan
- Single fetch, addr 0x80000004, ack 3 cycles after grant, mem_rdata_i=0x11112222_33334444 -> mem_req_o high 3 cycles, if_rvalid_o pulses at grant+4, if_rdata_o=0x11112222.
- Load and fetch requested in the same IDLE cycle, ack latency 1 -> LS granted first, IF granted on LS ack cycle, mem_req_o continuous with no gap. With ARB_RR_EN and an immediate second tie, IF wins the second tie.
- Store, ls_wmask_i=0x0F, ls_wdata_i=0xDEADBEEF -> mem_we_o=1, mem_wmask_o=0x0F, ls_rvalid_o pulses, ls_rdata_o unchanged.
- Fetch in IF_BUSY, flush_i pulsed 1 cycle, ack 2 cycles later -> no if_rvalid_o pulse; a new fetch granted on the ack cycle returns rvalid normally.
- rst_n asserted while LS_BUSY with mem_req_o high -> mem_req_o=0 and state IDLE asynchronously. A mem_ack_i after reset release produces no rvalid.
- Both requests held, ack latency 1, 8 transactions, fixed priority -> IF stays stalled while ls_req_i persists; stall_if_o=1 every cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/memory bus bundle for mem_arbiter: fetch port, load/store port,
// stall outputs and the single-port memory command/response.
interface mem_arbiter_if #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
);
  logic              flush_i;
  logic              if_req_i;
  logic [XLEN-1:0]   if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [INST_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [XLEN-1:0]   ls_addr_i;
  logic [XLEN-1:0]   ls_wdata_i;
  logic [7:0]        ls_wmask_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [XLEN-1:0]   ls_rdata_o;

  logic              stall_if_o;
  logic              stall_ls_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic [7:0]        mem_wmask_o;
  logic              mem_ack_i;
  logic [XLEN-1:0]   mem_rdata_i;

  modport slave (
    input  flush_i, if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  mem_ack_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output stall_if_o, stall_ls_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );

  modport master (
    output flush_i, if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output mem_ack_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  stall_if_o, stall_ls_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer sharing one port between IF fetch and LS access.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed LS-over-IF priority.
module mem_arbiter #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_wmask_q, mem_wmask_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [INST_W-1:0] if_rdata_q, if_rdata_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [XLEN-1:0]   ls_rdata_q, ls_rdata_d;
  logic              discard_q, discard_d;

  logic accept, ls_wins, if_gnt, ls_gnt, ack_if, ack_ls;

`ifdef ARB_RR_EN
  // Pointer holds the last granted requester (1 = LS); the other side wins a tie.
  logic rr_last_ls_q, rr_last_ls_d;
  assign ls_wins = ~rr_last_ls_q;

  always_comb begin
    rr_last_ls_d = rr_last_ls_q;
    if (ls_gnt)      rr_last_ls_d = 1'b1;
    else if (if_gnt) rr_last_ls_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_ls_q <= 1'b0;
    else        rr_last_ls_q <= rr_last_ls_d;
  end
`else
  assign ls_wins = 1'b1;
`endif

  always_comb begin
    accept = (state_q == IDLE) | bus.mem_ack_i;
    ack_if = (state_q == IF_BUSY) & bus.mem_ack_i;
    ack_ls = (state_q == LS_BUSY) & bus.mem_ack_i;
    ls_gnt = accept & bus.ls_req_i & (~bus.if_req_i | ls_wins);
    if_gnt = accept & bus.if_req_i & (~bus.ls_req_i | ~ls_wins);

    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    // A flush on the ack cycle itself must also kill that response.
    if_rvalid_d = ack_if & ~(discard_q | bus.flush_i);
    ls_rvalid_d = ack_ls;
    discard_d   = ack_if ? 1'b0
                         : (discard_q | ((state_q == IF_BUSY) & bus.flush_i));

    if (ack_if)
      if_rdata_d = mem_addr_q[2] ? bus.mem_rdata_i[XLEN-1:XLEN-INST_W]
                                 : bus.mem_rdata_i[INST_W-1:0];
    if (ack_ls & ~mem_we_q)
      ls_rdata_d = bus.mem_rdata_i;

    if (accept) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      if (ls_gnt) begin
        state_d     = LS_BUSY;
        mem_req_d   = 1'b1;
        mem_we_d    = bus.ls_we_i;
        mem_addr_d  = bus.ls_addr_i;
        mem_wdata_d = bus.ls_wdata_i;
        mem_wmask_d = bus.ls_wmask_i;
      end else if (if_gnt) begin
        state_d     = IF_BUSY;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.if_addr_i;
        mem_wdata_d = '0;
        mem_wmask_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      discard_q   <= discard_d;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rvalid_o = ls_rvalid_q;
  assign bus.ls_rdata_o  = ls_rdata_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wmask_o = mem_wmask_q;
  assign bus.stall_if_o  = (bus.if_req_i & ~if_gnt) | (state_q == IF_BUSY);
  assign bus.stall_ls_o  = (bus.ls_req_i & ~ls_gnt) | (state_q == LS_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: IDLE grant table, directed corner
// sequences, then random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit if_req;
    bit ls_req;
    bit e_if_gnt;
    bit e_ls_gnt;
    bit e_stall_if;
    bit e_stall_ls;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush_i     = 1'b0;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.ls_req_i    = 1'b0;
    bus.ls_we_i     = 1'b0;
    bus.ls_addr_i   = '0;
    bus.ls_wdata_i  = '0;
    bus.ls_wmask_i  = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // Transaction-level reference model state for the random phase.
  bit          m_busy, m_cur_ls, m_cur_we, m_discard, rr_ls_last;
  logic [63:0] m_addr;
  logic [7:0]  m_wmask;
  bit          e_if_rv, e_ls_rv;
  logic [31:0] e_if_data;
  logic [63:0] e_ls_data;

  initial begin
    vec_t vecs[4];
    vecs[0] = '{0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 1, 0, 0};
    vecs[3] = '{1, 1, 0, 1, 1, 0};

    rst_n = 1'b0;
    clear_inputs();
    do_reset();

    chk("rst_mem_req",   bus.mem_req_o,   0);
    chk("rst_mem_addr",  bus.mem_addr_o,  0);
    chk("rst_mem_we",    bus.mem_we_o,    0);
    chk("rst_if_rvalid", bus.if_rvalid_o, 0);
    chk("rst_ls_rvalid", bus.ls_rvalid_o, 0);
    chk("rst_if_rdata",  bus.if_rdata_o,  0);
    chk("rst_ls_rdata",  bus.ls_rdata_o,  0);

    // Grant/stall table in IDLE; requests are withdrawn before the edge.
    for (int i = 0; i < 4; i++) begin
      bus.if_req_i = vecs[i].if_req;
      bus.ls_req_i = vecs[i].ls_req;
      #1;
      chk("tbl_if_gnt",   bus.if_gnt_o,   vecs[i].e_if_gnt);
      chk("tbl_ls_gnt",   bus.ls_gnt_o,   vecs[i].e_ls_gnt);
      chk("tbl_stall_if", bus.stall_if_o, vecs[i].e_stall_if);
      chk("tbl_stall_ls", bus.stall_ls_o, vecs[i].e_stall_ls);
      bus.if_req_i = 1'b0;
      bus.ls_req_i = 1'b0;
      tick();
    end

    // Single fetch, ack three cycles after grant, upper word selected.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h0000_0000_8000_0004;
    #1;
    chk("f1_gnt", bus.if_gnt_o, 1);
    chk("f1_stall_if_gnt", bus.stall_if_o, 0);
    tick(); bus.if_req_i = 1'b0; #1;
    chk("f1_req_c1", bus.mem_req_o, 1);
    chk("f1_addr", bus.mem_addr_o, 64'h8000_0004);
    chk("f1_we", bus.mem_we_o, 0);
    chk("f1_wmask", bus.mem_wmask_o, 0);
    chk("f1_stall_busy", bus.stall_if_o, 1);
    tick(); #1;
    chk("f1_req_c2", bus.mem_req_o, 1);
    tick();
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h1111_2222_3333_4444;
    #1;
    chk("f1_req_c3", bus.mem_req_o, 1);
    chk("f1_rv_early", bus.if_rvalid_o, 0);
    tick(); bus.mem_ack_i = 1'b0; #1;
    chk("f1_rvalid", bus.if_rvalid_o, 1);
    chk("f1_rdata", bus.if_rdata_o, 32'h1111_2222);
    chk("f1_req_done", bus.mem_req_o, 0);
    tick(); #1;
    chk("f1_rv_pulse", bus.if_rvalid_o, 0);

    // Load and fetch tie, ack latency 1: LS first, IF granted on ack, no gap.
    bus.ls_req_i  = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'h1000;
    bus.if_req_i  = 1'b1; bus.if_addr_i = 64'h2000;
    #1;
    chk("tie_ls_gnt", bus.ls_gnt_o, 1);
    chk("tie_if_gnt", bus.if_gnt_o, 0);
    chk("tie_stall_if", bus.stall_if_o, 1);
    chk("tie_stall_ls", bus.stall_ls_o, 0);
    tick();
    bus.ls_req_i    = 1'b0;
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'hA5A5_A5A5_5A5A_5A5A;
    #1;
    chk("tie_ls_addr", bus.mem_addr_o, 64'h1000);
    chk("tie_if_gnt_ack", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i    = 1'b0;
    bus.mem_rdata_i = 64'h0000_0000_CAFE_F00D;
    #1;
    chk("tie_ls_rvalid", bus.ls_rvalid_o, 1);
    chk("tie_ls_rdata", bus.ls_rdata_o, 64'hA5A5_A5A5_5A5A_5A5A);
    chk("tie_no_gap", bus.mem_req_o, 1);
    chk("tie_if_addr", bus.mem_addr_o, 64'h2000);
    tick(); bus.mem_ack_i = 1'b0; #1;
    chk("tie_if_rvalid", bus.if_rvalid_o, 1);
    chk("tie_if_rdata", bus.if_rdata_o, 32'hCAFE_F00D);
    chk("tie_idle", bus.mem_req_o, 0);
    tick();

    // Store leaves load data untouched.
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_addr_i = 64'h3008;
    bus.ls_wdata_i = 64'hDEAD_BEEF; bus.ls_wmask_i = 8'h0F;
    #1;
    chk("st_gnt", bus.ls_gnt_o, 1);
    tick();
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("st_we", bus.mem_we_o, 1);
    chk("st_wmask", bus.mem_wmask_o, 8'h0F);
    chk("st_wdata", bus.mem_wdata_o, 64'hDEAD_BEEF);
    chk("st_stall_ls", bus.stall_ls_o, 1);
    tick(); bus.mem_ack_i = 1'b0; #1;
    chk("st_rvalid", bus.ls_rvalid_o, 1);
    chk("st_rdata_kept", bus.ls_rdata_o, 64'hA5A5_A5A5_5A5A_5A5A);
    tick(); #1;
    chk("st_rv_pulse", bus.ls_rvalid_o, 0);

    // Flush during a fetch; a new fetch granted on the ack cycle returns normally.
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h4000;
    #1;
    chk("fl_gnt", bus.if_gnt_o, 1);
    tick(); bus.if_req_i = 1'b0; bus.flush_i = 1'b1;
    tick(); bus.flush_i = 1'b0;
    tick();
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 64'h1234;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h4004;
    #1;
    chk("fl_gnt_ack", bus.if_gnt_o, 1);
    tick(); bus.mem_ack_i = 1'b0; bus.if_req_i = 1'b0; #1;
    chk("fl_suppressed", bus.if_rvalid_o, 0);
    chk("fl_next_req", bus.mem_req_o, 1);
    chk("fl_next_addr", bus.mem_addr_o, 64'h4004);
    tick(); bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 64'h8765_4321_0000_0000;
    tick(); bus.mem_ack_i = 1'b0; #1;
    chk("fl_new_rvalid", bus.if_rvalid_o, 1);
    chk("fl_new_rdata", bus.if_rdata_o, 32'h8765_4321);
    tick();

    // Asynchronous reset while LS_BUSY; later ack is ignored.
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'h5000;
    tick(); bus.ls_req_i = 1'b0; #1;
    chk("ar_busy", bus.mem_req_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_req_drop", bus.mem_req_o, 0);
    chk("ar_stall_ls", bus.stall_ls_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 64'h7777;
    tick(); bus.mem_ack_i = 1'b0; #1;
    chk("ar_no_rvalid", bus.ls_rvalid_o, 0);
    chk("ar_rdata", bus.ls_rdata_o, 0);
    tick(); #1;
    chk("ar_no_rvalid2", bus.ls_rvalid_o, 0);

`ifndef ARB_RR_EN
    // Both held, ack every busy cycle: LS wins all eight, IF stays stalled.
    bus.ls_req_i = 1'b1; bus.ls_addr_i = 64'h6000;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h7000;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ack_i = (i != 0);
      #1;
      chk("bb_ls_gnt", bus.ls_gnt_o, 1);
      chk("bb_if_gnt", bus.if_gnt_o, 0);
      chk("bb_stall_if", bus.stall_if_o, 1);
      tick();
    end
    bus.ls_req_i = 1'b0; bus.mem_ack_i = 1'b1;
    #1;
    chk("bb_if_last", bus.if_gnt_o, 1);
    tick(); bus.if_req_i = 1'b0;
    tick(); bus.mem_ack_i = 1'b0;
    tick();
`endif

    // Random traffic against the transaction model.
    do_reset();
    m_busy = 0; m_cur_ls = 0; m_cur_we = 0; m_discard = 0; rr_ls_last = 0;
    m_addr = '0; m_wmask = '0; e_if_rv = 0; e_ls_rv = 0;
    e_if_data = '0; e_ls_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit accept, ls_win, g_if, g_ls;
      if (!bus.if_req_i && $urandom_range(0, 2) == 0) begin
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = {$urandom, $urandom};
      end
      if (!bus.ls_req_i && $urandom_range(0, 2) == 0) begin
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = $urandom_range(0, 1) == 1;
        bus.ls_addr_i  = {$urandom, $urandom};
        bus.ls_wdata_i = {$urandom, $urandom};
        bus.ls_wmask_i = 8'($urandom);
      end
      bus.mem_ack_i   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      bus.mem_rdata_i = {$urandom, $urandom};
      bus.flush_i     = $urandom_range(0, 4) == 0;
      #1;

      chk("r_mem_req", bus.mem_req_o, m_busy);
      if (m_busy) begin
        chk("r_mem_addr", bus.mem_addr_o, m_addr);
        chk("r_mem_we", bus.mem_we_o, m_cur_we);
        chk("r_mem_wmask", bus.mem_wmask_o, m_wmask);
      end
      chk("r_if_rvalid", bus.if_rvalid_o, e_if_rv);
      if (e_if_rv) chk("r_if_rdata", bus.if_rdata_o, e_if_data);
      chk("r_ls_rvalid", bus.ls_rvalid_o, e_ls_rv);
      chk("r_ls_rdata", bus.ls_rdata_o, e_ls_data);

      accept = !m_busy || bus.mem_ack_i;
`ifdef ARB_RR_EN
      ls_win = !rr_ls_last;
`else
      ls_win = 1'b1;
`endif
      g_ls = accept && bus.ls_req_i && (!bus.if_req_i || ls_win);
      g_if = accept && bus.if_req_i && !g_ls;
      chk("r_if_gnt", bus.if_gnt_o, g_if);
      chk("r_ls_gnt", bus.ls_gnt_o, g_ls);
      chk("r_stall_if", bus.stall_if_o, (bus.if_req_i && !g_if) || (m_busy && !m_cur_ls));
      chk("r_stall_ls", bus.stall_ls_o, (bus.ls_req_i && !g_ls) || (m_busy && m_cur_ls));

      e_if_rv = 0;
      e_ls_rv = 0;
      if (m_busy && bus.mem_ack_i) begin
        if (!m_cur_ls) begin
          e_if_rv   = !(m_discard || bus.flush_i);
          e_if_data = m_addr[2] ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];
          m_discard = 0;
        end else begin
          e_ls_rv = 1;
          if (!m_cur_we) e_ls_data = bus.mem_rdata_i;
        end
      end else if (m_busy && !m_cur_ls && bus.flush_i) begin
        m_discard = 1;
      end
      if (accept) begin
        m_busy = g_if || g_ls;
        if (g_ls) begin
          m_cur_ls = 1; m_cur_we = bus.ls_we_i; m_addr = bus.ls_addr_i;
          m_wmask = bus.ls_wmask_i; rr_ls_last = 1;
        end else if (g_if) begin
          m_cur_ls = 0; m_cur_we = 0; m_addr = bus.if_addr_i;
          m_wmask = '0; rr_ls_last = 0;
        end
      end

      tick();
      if (g_if) bus.if_req_i = 1'b0;
      if (g_ls) bus.ls_req_i = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
